sr04_echo_responder: RTL and testbench

- Emulates the HC-SR04 ultrasonic sensor side of the trig/echo protocol; it is the responder to the SR04 controller FSM.
- Watches `trig`, checks that the trigger pulse is wide enough, waits a fixed burst delay, then drives `echo` high for a width that encodes a programmed distance (58 ticks per cm).
- Used for closed-loop FPGA and simulation testing of the ultrasonic measurement path without a physical sensor.

---
 rtl/sr04_echo_responder.sv | 174 +++++++++++++++++
 tb/tb_sr04_echo_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sr04_echo_responder.sv
// HC-SR04 sensor-side emulator: validates trig width, waits a burst delay, then drives an echo
// pulse whose width encodes i_dist (58 ticks/cm). Define SR04_ECHO_JITTER_EN for LFSR width jitter.
module sr04_echo_responder #(
    parameter int TRIG_MIN_US = 10,
    parameter int BURST_US    = 200,
    parameter int MAX_CM      = 400,
    parameter int TIMEOUT_US  = 38000,
    parameter int HOLDOFF_US  = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tick,
    input  logic       en,
    input  logic       trig,
    input  logic [8:0] i_dist,
    output logic       echo,
    output logic       o_busy,
    output logic       o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_DELAY,
        S_ECHO,
        S_HOLDOFF
    } state_t;

    localparam logic [15:0] TRIG_MIN     = 16'(TRIG_MIN_US);
    localparam logic [15:0] BURST_LAST   = 16'(BURST_US - 1);
    localparam logic [15:0] HOLDOFF_LAST = 16'(HOLDOFF_US - 1);
    localparam logic [15:0] TIMEOUT_W    = 16'(TIMEOUT_US);
    localparam logic [8:0]  MAX_DIST     = 9'(MAX_CM);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] w_q, w_d;
    logic        echo_q, echo_d;
    logic        err_q, err_d;
    logic        trig_s1_q, trig_s2_q, trig_prev_q;

    logic        trig_fall;
    logic [15:0] cnt_sat;
    logic [15:0] w_base;

`ifdef SR04_ECHO_JITTER_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] lfsr_shift;
    // x^8 + x^6 + x^5 + x^4 + 1, shifted left
    assign lfsr_shift = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif

    assign trig_fall = trig_prev_q & ~trig_s2_q;
    assign cnt_sat   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign w_base    = (i_dist == 9'd0 || i_dist > MAX_DIST) ? TIMEOUT_W
                                                             : 16'(i_dist) * 16'd58;

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        echo_d  = echo_q;
        err_d   = 1'b0;
`ifdef SR04_ECHO_JITTER_EN
        lfsr_d  = lfsr_q;
`endif
        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = 16'd0;
            echo_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    cnt_d  = 16'd0;
                    echo_d = 1'b0;
                    if (trig_s2_q) state_d = S_TRIG;
                end
                S_TRIG: begin
                    // A tick on the falling-edge cycle is dropped; the decision uses cnt_q.
                    if (trig_fall) begin
                        cnt_d = 16'd0;
                        if (cnt_q >= TRIG_MIN) begin
                            state_d = S_DELAY;
`ifdef SR04_ECHO_JITTER_EN
                            lfsr_d  = lfsr_shift;
                            w_d     = w_base + {13'd0, lfsr_shift[2:0]};
`else
                            w_d     = w_base;
`endif
                        end else begin
                            state_d = S_IDLE;
                            err_d   = 1'b1;
                        end
                    end else if (i_tick) begin
                        cnt_d = cnt_sat;
                    end
                end
                S_DELAY: begin
                    if (i_tick) begin
                        if (cnt_q == BURST_LAST) begin
                            state_d = S_ECHO;
                            cnt_d   = 16'd0;
                            echo_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end
                S_ECHO: begin
                    if (i_tick) begin
                        if (cnt_q == w_q - 16'd1) begin
                            state_d = S_HOLDOFF;
                            cnt_d   = 16'd0;
                            echo_d  = 1'b0;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end
                S_HOLDOFF: begin
                    echo_d = 1'b0;
                    if (i_tick) begin
                        if (cnt_q == HOLDOFF_LAST) begin
                            state_d = S_IDLE;
                            cnt_d   = 16'd0;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 16'd0;
                    echo_d  = 1'b0;
                end
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            w_q         <= 16'd0;
            echo_q      <= 1'b0;
            err_q       <= 1'b0;
            trig_s1_q   <= 1'b0;
            trig_s2_q   <= 1'b0;
            trig_prev_q <= 1'b0;
`ifdef SR04_ECHO_JITTER_EN
            lfsr_q      <= 8'h01;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            w_q         <= w_d;
            echo_q      <= echo_d;
            err_q       <= err_d;
            trig_s1_q   <= trig;
            trig_s2_q   <= trig_s1_q;
            trig_prev_q <= trig_s2_q;
`ifdef SR04_ECHO_JITTER_EN
            lfsr_q      <= lfsr_d;
`endif
        end
    end

    assign echo   = echo_q;
    assign o_err  = err_q;
    assign o_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_sr04_echo_responder.sv
// Directed bench for sr04_echo_responder: i_tick every 2 clk, echo widths measured in clk.
module tb_sr04_echo_responder;

    localparam int TIMEOUT = 1200;
    localparam int TP      = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_tick = 1'b0;
    logic       en;
    logic       trig;
    logic [8:0] i_dist;
    logic       echo;
    logic       o_busy;
    logic       o_err;

    int     total = 0;
    int     bad   = 0;
    int     n_rises = 0;
    int     n_falls = 0;
    int     n_err = 0;
    longint rise_t = 0;
    longint fall_t = 0;
    longint echo_fall_t = 0;
    longint width_clk = 0;
    logic   echo_prev = 1'b0;
`ifdef SR04_ECHO_JITTER_EN
    logic [7:0] lfsr_m = 8'h01;
`endif

    sr04_echo_responder #(.TIMEOUT_US(TIMEOUT)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_tick (i_tick),
        .en     (en),
        .trig   (trig),
        .i_dist (i_dist),
        .echo   (echo),
        .o_busy (o_busy),
        .o_err  (o_err)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            i_tick = ~i_tick;
        end
    end

    always @(posedge clk) begin
        #1;
        if (echo && !echo_prev) begin
            n_rises++;
            rise_t = $time;
        end
        if (!echo && echo_prev) begin
            n_falls++;
            width_clk   = ($time - rise_t) / 10;
            echo_fall_t = $time;
        end
        echo_prev = echo;
        if (o_err) n_err++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int exp_w(input int d);
        int w;
        w = (d == 0 || d > 400) ? TIMEOUT : d * 58;
`ifdef SR04_ECHO_JITTER_EN
        lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
        w += int'(lfsr_m[2:0]);
`endif
        return w;
    endfunction

    task automatic trig_pulse(input int us);
        @(negedge clk);
        trig = 1'b1;
        repeat (us * TP) @(negedge clk);
        trig = 1'b0;
        fall_t = $time;
    endtask

    task automatic wait_rise(input int budget, input string tag);
        int s;
        s = n_rises;
        for (int i = 0; i < budget && n_rises == s; i++) @(negedge clk);
        check(tag, n_rises, s + 1);
    endtask

    task automatic wait_fall(input int budget, input string tag);
        int s;
        s = n_falls;
        for (int i = 0; i < budget && n_falls == s; i++) @(negedge clk);
        check(tag, n_falls, s + 1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int i = 0; i < budget && o_busy; i++) @(negedge clk);
        check(tag, o_busy, 1'b0);
    endtask

    task automatic run_echo(input int d, input int w, input string tag);
        i_dist = 9'(d);
        trig_pulse(12);
        wait_rise(600, {tag, "_rise"});
        wait_fall(w * TP + 100, {tag, "_fall"});
        check({tag, "_width"}, width_clk, w * TP);
        wait_idle(2200, {tag, "_idle"});
    endtask

    initial begin
        int w;
        int r0;
        int e0;
        longint d;
        rst = 1'b0; en = 1'b0; trig = 1'b0; i_dist = 9'd0;
        repeat (3) @(negedge clk);
        check("rst_echo", echo, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_err", o_err, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        en = 1'b1;

        // controller loopback, 100 cm
        i_dist = 9'd100;
        w = exp_w(100);
        trig_pulse(12);
        repeat (5) @(negedge clk);
        check("loop_busy", o_busy, 1'b1);
        wait_rise(600, "loop_rise");
        d = (rise_t - fall_t) / 10;
        check("loop_delay_400clk", (d >= 398 && d <= 406), 1'b1);
        wait_fall(w * TP + 100, "loop_fall");
        check("loop_width", width_clk, w * TP);
        check("holdoff_busy", o_busy, 1'b1);
        wait_idle(2200, "loop_idle");
        d = ($time - echo_fall_t) / 10;
        check("holdoff_len", (d >= 1990 && d <= 2010), 1'b1);

        // short trigger rejected
        e0 = n_err; r0 = n_rises;
        trig_pulse(5);
        repeat (5) @(negedge clk);
        check("short_err_pulse", n_err, e0 + 1);
        check("short_busy", o_busy, 1'b0);
        repeat (600) @(negedge clk);
        check("short_no_echo", n_rises, r0);

        // out of range, zero distance, and the smallest in-range distance
        run_echo(450, exp_w(450), "oor450");
        run_echo(0, exp_w(0), "zero");
        run_echo(1, exp_w(1), "dist1");

        // retrigger mid-echo and during holdoff are ignored
        i_dist = 9'd10;
        w = exp_w(10);
        e0 = n_err;
        trig_pulse(12);
        wait_rise(600, "retrig_rise");
        r0 = n_rises;
        repeat (100) @(negedge clk);
        trig_pulse(12);
        wait_fall(w * TP + 100, "retrig_fall");
        check("retrig_width", width_clk, w * TP);
        repeat (100) @(negedge clk);
        trig_pulse(12);
        wait_idle(2200, "retrig_idle");
        repeat (20) @(negedge clk);
        check("holdoff_trig_ignored", n_rises, r0);
        check("holdoff_busy_low", o_busy, 1'b0);
        check("retrig_no_err", n_err, e0);
        run_echo(10, exp_w(10), "after_holdoff");

        // en abort mid-echo
        i_dist = 9'd50;
        w = exp_w(50);
        e0 = n_err;
        trig_pulse(12);
        wait_rise(600, "abort_en_rise");
        repeat (200) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("abort_en_echo", echo, 1'b0);
        check("abort_en_busy", o_busy, 1'b0);
        check("abort_en_no_err", n_err, e0);
        en = 1'b1;
        repeat (5) @(negedge clk);

        // reset abort mid-echo
        w = exp_w(50);
        trig_pulse(12);
        wait_rise(600, "abort_rst_rise");
        repeat (200) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_rst_echo", echo, 1'b0);
        check("abort_rst_busy", o_busy, 1'b0);
`ifdef SR04_ECHO_JITTER_EN
        lfsr_m = 8'h01;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        run_echo(50, exp_w(50), "post_rst");

        // jitter sequence from a fresh seed
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
`ifdef SR04_ECHO_JITTER_EN
        run_echo(10, 582, "jit0");
        run_echo(10, 584, "jit1");
        run_echo(10, 580, "jit2");
`else
        run_echo(10, 580, "jit0");
        run_echo(10, 580, "jit1");
        run_echo(10, 580, "jit2");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
